tx_os_scheduler: RTL and testbench
==================================

# tx_os_scheduler

Sequencer and arbiter between the MAC transmit stream and PHY-generated ordered sets, sitting in the PCLK domain directly in front of the PCS encoder input (MAC_TX_Data / MAC_TX_DataK / MAC_Data_En). It inserts SKP ordered sets at a programmable symbol interval and sequences electrical-idle entry (EIOS) and exit. It back-pressures the MAC with a valid/ready handshake while an ordered set occupies the lane.

## Interface
- SKP_INTERVAL, 1180: symbol count between SKP ordered sets (legal 16..4095).
- PCLK  in  1  parallel clock; all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- DataBusWidth  in  6  8/16/32 → 1/2/4 symbols per cycle (spc); any other value treated as 8. Latched on IDLE→DATA, ignored elsewhere.
- mac_data  in  32  MAC symbols, byte 0 (bits 7:0) transmitted first.
- mac_datak  in  4  per-byte K flag.
- mac_valid  in  1  mac_data valid.
- mac_ready  out  1  beat accepted on valid && ready.
- skp_en  in  1  enables SKP insertion.
- elec_idle_req  in  1  level request for electrical idle.
- tx_data  out  32  to PCS MAC_TX_Data.
- tx_datak  out  4  to PCS MAC_TX_DataK.
- tx_data_en  out  1  to PCS MAC_Data_En.
- tx_elec_idle  out  1  lane in electrical idle.
- skp_inserted  out  1  one-cycle pulse with first SKP beat.

## Operation
- States: IDLE, DATA, SKP, EIOS. Reset → IDLE.
- Constants: COM=0xBC, SKP=0x1C, IDL=0x7C, all K. Ordered set = COM + 3 fill symbols; occupies 4/spc beats (4, 2, 1), symbols packed from byte 0 upward.
- Unused lanes (bytes ≥ spc) drive data 0, datak 0 in every state.
- IDLE: tx_elec_idle=1, tx_data_en=0, tx_data/tx_datak=0, mac_ready=0, skp counter held at 0. elec_idle_req low → DATA.
- DATA: tx_elec_idle=0, tx_data_en=1. Accepted beat is forwarded; with mac_valid=0, logical idle (data 0, datak 0) is sent. Skp counter += spc every DATA cycle; when counter+spc ≥ SKP_INTERVAL and skp_en=1, skp_due is set at that edge (counter saturates at 4095).
- Priority at a DATA beat boundary: eios_due (registered elec_idle_req) > skp_due > MAC data.
- mac_ready = (state==DATA) && !skp_due && !eios_due; purely registered terms, no input combinational path.
- SKP: sends COM,SKP,SKP,SKP; counter cleared and skp_due cleared on entry; returns to DATA after last beat. An eios_due arriving during SKP waits for SKP completion.
- EIOS: sends COM,IDL,IDL,IDL; then IDLE. skp_due and counter cleared on IDLE entry.
- Ordered sets are never truncated; elec_idle_req deassertion during EIOS does not abort it.
- skp_en low: counter keeps running, skp_due not set; raising skp_en with counter already ≥ threshold sets skp_due next edge.

## Timing
- All outputs registered; reset values: tx_data 0, tx_datak 0, tx_data_en 0, tx_elec_idle 1, mac_ready 0, skp_inserted 0.
- MAC beat accepted at edge n appears on tx_data after edge n (latency 1).
- First ordered-set beat appears after the edge in which mac_ready was low due to skp_due/eios_due.
- elec_idle_req rise → eios_due at next edge → EIOS starts at following boundary.
- IDLE exit: elec_idle_req low at edge n → DATA at n, tx_elec_idle=0 and tx_data_en=1 after edge n+1.
- tx_elec_idle rises on the cycle after the last EIOS beat.
- Reset_n assertion mid-ordered-set: immediate return to reset values, no completion.

## Structure
- Package tx_sched_pkg: state enum, K-code constants (COM/SKP/IDL), spc decode function from DataBusWidth.
- One sub-module, tx_skp_timer: saturating symbol counter, threshold compare, skp_due flag, clear input.
- Top holds FSM, beat index within ordered set, output registers.

## Test plan
- 32-bit, skp_en=1, mac_valid=1 constant: 295 beats accepted, mac_ready low on beat 296, tx_data=0x1C1C1CBC tx_datak=0xF one cycle with skp_inserted, data resumes next cycle with no beat lost.
- 8-bit: SKP appears as 4 beats 0xBC,0x1C,0x1C,0x1C datak bit0=1, bytes 3:1 zero, after 1180 DATA cycles.
- elec_idle_req during 16-bit traffic: two beats 0x7CBC then 0x7C7C datak 0x3, then tx_elec_idle=1, tx_data_en=0.
- elec_idle_req and skp_due set same edge: EIOS sent, no SKP, counter 0 after re-entering DATA.
- Reset_n pulsed during 8-bit SKP beat 2: outputs at reset values immediately, IDLE after release.
- skp_en=0 for 2000 symbols then 1: SKP issued within one beat boundary after skp_en rises.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types, K-codes and lane-width helpers for the TX ordered-set scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_SKP, ST_EIOS} state_e;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  datak;
  } beat_t;

  // Symbols per cycle; unknown widths fall back to 8-bit operation.
  function automatic logic [2:0] spc_decode(input logic [5:0] w);
    case (w)
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] os_beats(input logic [2:0] spc);
    case (spc)
      3'd2:    return 3'd2;
      3'd4:    return 3'd1;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] spc);
    case (spc)
      3'd2:    return 4'b0011;
      3'd4:    return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  // Beat idx of a COM + 3-fill ordered set, packed from byte 0 upward.
  function automatic beat_t os_beat(input logic [7:0] fill, input logic [2:0] spc,
                                    input logic [2:0] idx);
    beat_t      b;
    logic [3:0] m;
    m = lane_mask(spc);
    b = '0;
    for (int j = 0; j < 4; j++) begin
      if (m[j]) begin
        b.data[8*j +: 8] = (idx == 3'd0 && j == 0) ? K_COM : fill;
        b.datak[j]       = 1'b1;
      end
    end
    return b;
  endfunction

  function automatic beat_t mask_beat(input beat_t b, input logic [2:0] spc);
    beat_t      r;
    logic [3:0] m;
    m = lane_mask(spc);
    r = '0;
    for (int j = 0; j < 4; j++) begin
      if (m[j]) begin
        r.data[8*j +: 8] = b.data[8*j +: 8];
        r.datak[j]       = b.datak[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_os_scheduler_if.sv
// MAC-side valid/ready stream and PCS-side transmit bus of the ordered-set scheduler.
interface tx_os_scheduler_if;
  logic [31:0] mac_data;
  logic [3:0]  mac_datak;
  logic        mac_valid;
  logic        mac_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_datak;
  logic        tx_data_en;

  modport master (output mac_data, mac_datak, mac_valid,
                  input  mac_ready, tx_data, tx_datak, tx_data_en);
  modport slave  (input  mac_data, mac_datak, mac_valid,
                  output mac_ready, tx_data, tx_datak, tx_data_en);
endinterface

// File: rtl/tx_skp_timer.sv
// Saturating symbol counter that raises a sticky skp_due once the SKP interval is reached.
module tx_skp_timer
  import tx_sched_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic       PCLK,
  input  logic       Reset_n,
  input  logic       run,
  input  logic       clr,
  input  logic       skp_en,
  input  logic [2:0] spc,
  output logic       skp_due,
  output logic       skp_due_nxt
);

  localparam logic [12:0] THRESH = 13'(SKP_INTERVAL);

  logic [11:0] count_q, count_d;
  logic        skp_due_q, skp_due_d;
  logic [12:0] sum;

  always_comb begin
    sum       = {1'b0, count_q} + {10'd0, spc};
    count_d   = count_q;
    skp_due_d = skp_due_q;
    if (clr) begin
      count_d   = '0;
      skp_due_d = 1'b0;
    end else if (run) begin
      count_d = sum[12] ? 12'hFFF : sum[11:0];
      // Compare on the post-increment value so a late skp_en still fires.
      if (skp_en && sum >= THRESH) skp_due_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q   <= '0;
      skp_due_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      skp_due_q <= skp_due_d;
    end
  end

  assign skp_due     = skp_due_q;
  assign skp_due_nxt = skp_due_d;

endmodule

// File: rtl/tx_os_scheduler.sv
// Arbitrates MAC beats against SKP and EIOS ordered sets in front of the PCS encoder.
module tx_os_scheduler
  import tx_sched_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic             PCLK,
  input  logic             Reset_n,
  input  logic [5:0]       DataBusWidth,
  tx_os_scheduler_if.slave bus,
  input  logic             skp_en,
  input  logic             elec_idle_req,
  output logic             tx_elec_idle,
  output logic             skp_inserted
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] spc_q, spc_d;
  logic       eios_due_q, eios_due_d;
  logic       mac_ready_q, mac_ready_d;
  beat_t      tx_q, tx_d;
  logic       data_en_q, data_en_d;
  logic       elec_idle_q, elec_idle_d;
  logic       skp_ins_q, skp_ins_d;

  logic       skp_due, skp_due_nxt, skp_start, skp_clr, accept;
  logic [2:0] beats;
  beat_t      mac_beat;

  assign beats    = os_beats(spc_q);
  assign accept   = bus.mac_valid && mac_ready_q;
  assign mac_beat = mask_beat({bus.mac_data, bus.mac_datak}, spc_q);
  assign skp_clr  = skp_start || (state_d == ST_IDLE);

  tx_skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_timer (
    .PCLK        (PCLK),
    .Reset_n     (Reset_n),
    .run         (state_q == ST_DATA),
    .clr         (skp_clr),
    .skp_en      (skp_en),
    .spc         (spc_q),
    .skp_due     (skp_due),
    .skp_due_nxt (skp_due_nxt)
  );

  // Outputs are registered from the current state, so each ordered-set beat is
  // loaded on the edge that also advances idx.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spc_d       = spc_q;
    eios_due_d  = elec_idle_req;
    tx_d        = '0;
    data_en_d   = 1'b0;
    elec_idle_d = 1'b0;
    skp_ins_d   = 1'b0;
    skp_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        elec_idle_d = 1'b1;
        if (!elec_idle_req) begin
          state_d = ST_DATA;
          spc_d   = spc_decode(DataBusWidth);
        end
      end
      ST_DATA: begin
        data_en_d = 1'b1;
        if (eios_due_q) begin
          tx_d    = os_beat(K_IDL, spc_q, 3'd0);
          idx_d   = 3'd1;
          state_d = ST_EIOS;
        end else if (skp_due) begin
          tx_d      = os_beat(K_SKP, spc_q, 3'd0);
          skp_ins_d = 1'b1;
          skp_start = 1'b1;
          idx_d     = 3'd1;
          state_d   = (beats == 3'd1) ? ST_DATA : ST_SKP;
        end else if (accept) begin
          tx_d = mac_beat;
        end
      end
      ST_SKP: begin
        data_en_d = 1'b1;
        tx_d      = os_beat(K_SKP, spc_q, idx_q);
        if (idx_q == beats - 3'd1) state_d = ST_DATA;
        else                       idx_d   = idx_q + 3'd1;
      end
      ST_EIOS: begin
        // Hold EIOS one extra cycle so the last beat is on the wire before idle.
        if (idx_q == beats) begin
          state_d     = ST_IDLE;
          elec_idle_d = 1'b1;
        end else begin
          data_en_d = 1'b1;
          tx_d      = os_beat(K_IDL, spc_q, idx_q);
          idx_d     = idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mac_ready_d = (state_d == ST_DATA) && !skp_due_nxt && !eios_due_d;
  end

  always_ff @(posedge PCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      spc_q       <= 3'd1;
      eios_due_q  <= 1'b0;
      mac_ready_q <= 1'b0;
      tx_q        <= '0;
      data_en_q   <= 1'b0;
      elec_idle_q <= 1'b1;
      skp_ins_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spc_q       <= spc_d;
      eios_due_q  <= eios_due_d;
      mac_ready_q <= mac_ready_d;
      tx_q        <= tx_d;
      data_en_q   <= data_en_d;
      elec_idle_q <= elec_idle_d;
      skp_ins_q   <= skp_ins_d;
    end
  end

  assign bus.mac_ready  = mac_ready_q;
  assign bus.tx_data    = tx_q.data;
  assign bus.tx_datak   = tx_q.datak;
  assign bus.tx_data_en = data_en_q;
  assign tx_elec_idle   = elec_idle_q;
  assign skp_inserted   = skp_ins_q;

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Scenario bench for tx_os_scheduler: MAC beats scoreboarded, ordered sets checked per beat.
module tb_tx_os_scheduler;

  logic       PCLK = 1'b0;
  logic       Reset_n;
  logic [5:0] DataBusWidth;
  logic       skp_en, elec_idle_req, tx_elec_idle, skp_inserted;

  tx_os_scheduler_if bus ();

  tx_os_scheduler #(.SKP_INTERVAL(1180)) dut (
    .PCLK          (PCLK),
    .Reset_n       (Reset_n),
    .DataBusWidth  (DataBusWidth),
    .bus           (bus),
    .skp_en        (skp_en),
    .elec_idle_req (elec_idle_req),
    .tx_elec_idle  (tx_elec_idle),
    .skp_inserted  (skp_inserted)
  );

  always #5 PCLK = ~PCLK;

  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  logic [31:0] lane_m;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] next_word();
    logic [31:0] w;
    w    = $urandom();
    w[0] = 1'b1;
    return w;
  endfunction

  // One clock: push accepted beat, advance, pop any MAC beat the DUT emits.
  task automatic tick();
    bit          acc;
    logic [31:0] e;
    acc = (bus.mac_valid === 1'b1) && (bus.mac_ready === 1'b1);
    if (acc) exp_q.push_back(bus.mac_data & lane_m);
    @(posedge PCLK);
    #1;
    if (acc) begin
      bus.mac_data = next_word();
      n_acc++;
    end
    if (Reset_n && bus.tx_data_en === 1'b1 && bus.tx_datak === 4'h0 && bus.tx_data !== 32'h0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got %h want no beat", bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          bad++;
          $display("FAIL sb_data: got %h want %h", bus.tx_data, e);
        end
      end
    end
  endtask

  task automatic apply_reset(input logic [5:0] width);
    Reset_n        = 1'b0;
    elec_idle_req  = 1'b1;
    skp_en         = 1'b1;
    bus.mac_valid  = 1'b0;
    bus.mac_datak  = 4'h0;
    bus.mac_data   = next_word();
    DataBusWidth   = width;
    lane_m         = (width == 6'd32) ? 32'hFFFF_FFFF : (width == 6'd16) ? 32'h0000_FFFF : 32'h0000_00FF;
    exp_q.delete();
    repeat (2) @(posedge PCLK);
    #1;
    Reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic start_link();
    elec_idle_req = 1'b0;
    tick();
    n_acc = 0;
  endtask

  task automatic test_reset();
    Reset_n       = 1'b0;
    elec_idle_req = 1'b1;
    skp_en        = 1'b1;
    bus.mac_valid = 1'b0;
    bus.mac_datak = 4'h0;
    bus.mac_data  = 32'h1;
    DataBusWidth  = 6'd8;
    lane_m        = 32'hFF;
    #12;
    total++; if (bus.tx_data !== 32'h0)     begin bad++; $display("FAIL rst_data: got %h want 0", bus.tx_data); end
    total++; if (bus.tx_datak !== 4'h0)     begin bad++; $display("FAIL rst_datak: got %h want 0", bus.tx_datak); end
    total++; if (bus.tx_data_en !== 1'b0)   begin bad++; $display("FAIL rst_en: got %b want 0", bus.tx_data_en); end
    total++; if (tx_elec_idle !== 1'b1)     begin bad++; $display("FAIL rst_eidle: got %b want 1", tx_elec_idle); end
    total++; if (bus.mac_ready !== 1'b0)    begin bad++; $display("FAIL rst_ready: got %b want 0", bus.mac_ready); end
    total++; if (skp_inserted !== 1'b0)     begin bad++; $display("FAIL rst_skp: got %b want 0", skp_inserted); end
    @(posedge PCLK); #1;
    Reset_n = 1'b1;
    repeat (3) tick();
    total++; if (tx_elec_idle !== 1'b1 || bus.tx_data_en !== 1'b0)
      begin bad++; $display("FAIL idle_hold: got eidle=%b en=%b want 1/0", tx_elec_idle, bus.tx_data_en); end
  endtask

  task automatic test_skp32();
    int guard;
    apply_reset(6'd32);
    bus.mac_valid = 1'b1;
    start_link();
    total++; if (tx_elec_idle !== 1'b1 || bus.mac_ready !== 1'b1)
      begin bad++; $display("FAIL exit_n: got eidle=%b ready=%b want 1/1", tx_elec_idle, bus.mac_ready); end
    tick();
    total++; if (tx_elec_idle !== 1'b0 || bus.tx_data_en !== 1'b1)
      begin bad++; $display("FAIL exit_n1: got eidle=%b en=%b want 0/1", tx_elec_idle, bus.tx_data_en); end
    guard = 0;
    while (bus.mac_ready === 1'b1 && guard < 400) begin tick(); guard++; end
    total++; if (n_acc != 295) begin bad++; $display("FAIL skp32_beats: got %0d want 295", n_acc); end
    tick();
    total++; if (bus.tx_data !== 32'h1C1C1CBC || bus.tx_datak !== 4'hF)
      begin bad++; $display("FAIL skp32_os: got %h/%h want 1c1c1cbc/f", bus.tx_data, bus.tx_datak); end
    total++; if (skp_inserted !== 1'b1 || bus.mac_ready !== 1'b1)
      begin bad++; $display("FAIL skp32_flags: got skp=%b ready=%b want 1/1", skp_inserted, bus.mac_ready); end
    tick();
    total++; if (skp_inserted !== 1'b0 || exp_q.size() != 0)
      begin bad++; $display("FAIL skp32_resume: got skp=%b pending=%0d want 0/0", skp_inserted, exp_q.size()); end
    bus.mac_valid = 1'b0;
  endtask

  task automatic test_skp8();
    int         cyc;
    logic [7:0] want;
    apply_reset(6'd8);
    bus.mac_valid = 1'b1;
    start_link();
    cyc = 0;
    while (skp_inserted !== 1'b1 && cyc < 1300) begin tick(); cyc++; end
    total++; if (cyc != 1181) begin bad++; $display("FAIL skp8_cycles: got %0d want 1181", cyc); end
    total++; if (n_acc != 1180) begin bad++; $display("FAIL skp8_beats: got %0d want 1180", n_acc); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      want = (k == 0) ? 8'hBC : 8'h1C;
      total++;
      if (bus.tx_data !== {24'h0, want} || bus.tx_datak !== 4'h1 || skp_inserted !== (k == 0) ||
          bus.mac_ready !== (k == 3))
        begin bad++; $display("FAIL skp8_beat%0d: got %h/%h skp=%b rdy=%b want %h/1", k, bus.tx_data,
                              bus.tx_datak, skp_inserted, bus.mac_ready, want); end
    end
    bus.mac_valid = 1'b0;
    tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL skp8_drain: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_eios16();
    apply_reset(6'd16);
    bus.mac_valid = 1'b1;
    start_link();
    repeat (10) tick();
    elec_idle_req = 1'b1;
    tick();
    total++; if (bus.mac_ready !== 1'b0 || bus.tx_data_en !== 1'b1)
      begin bad++; $display("FAIL eios_ready: got rdy=%b en=%b want 0/1", bus.mac_ready, bus.tx_data_en); end
    tick();
    total++; if (bus.tx_data !== 32'h00007CBC || bus.tx_datak !== 4'h3)
      begin bad++; $display("FAIL eios_b0: got %h/%h want 00007cbc/3", bus.tx_data, bus.tx_datak); end
    elec_idle_req = 1'b0;
    tick();
    total++; if (bus.tx_data !== 32'h00007C7C || bus.tx_datak !== 4'h3 || tx_elec_idle !== 1'b0)
      begin bad++; $display("FAIL eios_b1: got %h/%h eidle=%b want 00007c7c/3/0", bus.tx_data, bus.tx_datak, tx_elec_idle); end
    tick();
    total++; if (tx_elec_idle !== 1'b1 || bus.tx_data_en !== 1'b0 || bus.tx_data !== 32'h0)
      begin bad++; $display("FAIL eios_idle: got eidle=%b en=%b d=%h want 1/0/0", tx_elec_idle, bus.tx_data_en, bus.tx_data); end
    tick();
    total++; if (tx_elec_idle !== 1'b1 || bus.mac_ready !== 1'b1)
      begin bad++; $display("FAIL reexit_n: got eidle=%b rdy=%b want 1/1", tx_elec_idle, bus.mac_ready); end
    tick();
    total++; if (tx_elec_idle !== 1'b0 || bus.tx_data_en !== 1'b1)
      begin bad++; $display("FAIL reexit_n1: got eidle=%b en=%b want 0/1", tx_elec_idle, bus.tx_data_en); end
    bus.mac_valid = 1'b0;
    tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL eios_drain: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_collide();
    int guard;
    apply_reset(6'd32);
    bus.mac_valid = 1'b1;
    start_link();
    repeat (294) tick();
    elec_idle_req = 1'b1;
    tick();
    total++; if (bus.mac_ready !== 1'b0) begin bad++; $display("FAIL col_ready: got %b want 0", bus.mac_ready); end
    tick();
    total++; if (bus.tx_data !== 32'h7C7C7CBC || bus.tx_datak !== 4'hF || skp_inserted !== 1'b0)
      begin bad++; $display("FAIL col_eios: got %h/%h skp=%b want 7c7c7cbc/f/0", bus.tx_data, bus.tx_datak, skp_inserted); end
    tick();
    total++; if (tx_elec_idle !== 1'b1 || bus.tx_data_en !== 1'b0)
      begin bad++; $display("FAIL col_idle: got eidle=%b en=%b want 1/0", tx_elec_idle, bus.tx_data_en); end
    elec_idle_req = 1'b0;
    start_link();
    guard = 0;
    while (bus.mac_ready === 1'b1 && guard < 400) begin tick(); guard++; end
    total++; if (n_acc != 295) begin bad++; $display("FAIL col_restart: got %0d want 295", n_acc); end
    tick();
    total++; if (skp_inserted !== 1'b1) begin bad++; $display("FAIL col_skp: got %b want 1", skp_inserted); end
    bus.mac_valid = 1'b0;
  endtask

  task automatic test_reset_mid_os();
    int cyc;
    apply_reset(6'd8);
    start_link();
    cyc = 0;
    while (skp_inserted !== 1'b1 && cyc < 1300) begin tick(); cyc++; end
    total++; if (cyc != 1181) begin bad++; $display("FAIL rmid_cycles: got %0d want 1181", cyc); end
    tick();
    total++; if (bus.tx_data !== 32'h1C || bus.tx_datak !== 4'h1)
      begin bad++; $display("FAIL rmid_b1: got %h/%h want 0000001c/1", bus.tx_data, bus.tx_datak); end
    #1;
    Reset_n       = 1'b0;
    elec_idle_req = 1'b1;
    #1;
    total++; if (bus.tx_data !== 32'h0 || bus.tx_datak !== 4'h0 || bus.tx_data_en !== 1'b0 ||
                 tx_elec_idle !== 1'b1 || bus.mac_ready !== 1'b0 || skp_inserted !== 1'b0)
      begin bad++; $display("FAIL rmid_rst: got %h/%h en=%b eidle=%b rdy=%b skp=%b want reset values",
                            bus.tx_data, bus.tx_datak, bus.tx_data_en, tx_elec_idle, bus.mac_ready, skp_inserted); end
    @(posedge PCLK); #1;
    Reset_n = 1'b1;
    tick();
    tick();
    total++; if (tx_elec_idle !== 1'b1 || bus.tx_data_en !== 1'b0 || bus.tx_data !== 32'h0)
      begin bad++; $display("FAIL rmid_idle: got eidle=%b en=%b d=%h want 1/0/0", tx_elec_idle, bus.tx_data_en, bus.tx_data); end
  endtask

  task automatic test_skp_en_late();
    int odd;
    apply_reset(6'd16);
    skp_en        = 1'b0;
    bus.mac_valid = 1'b1;
    start_link();
    odd = 0;
    repeat (2100) begin
      tick();
      if (bus.mac_ready !== 1'b1 || skp_inserted !== 1'b0) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL sen_off: got %0d stalls want 0", odd); end
    skp_en = 1'b1;
    tick();
    total++; if (bus.mac_ready !== 1'b0) begin bad++; $display("FAIL sen_ready: got %b want 0", bus.mac_ready); end
    tick();
    total++; if (bus.tx_data !== 32'h00001CBC || bus.tx_datak !== 4'h3 || skp_inserted !== 1'b1)
      begin bad++; $display("FAIL sen_b0: got %h/%h skp=%b want 00001cbc/3/1", bus.tx_data, bus.tx_datak, skp_inserted); end
    tick();
    total++; if (bus.tx_data !== 32'h00001C1C || skp_inserted !== 1'b0 || bus.mac_ready !== 1'b1)
      begin bad++; $display("FAIL sen_b1: got %h skp=%b rdy=%b want 00001c1c/0/1", bus.tx_data, skp_inserted, bus.mac_ready); end
    bus.mac_valid = 1'b0;
    tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sen_drain: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_skp32();
    test_skp8();
    test_eios16();
    test_collide();
    test_reset_mid_os();
    test_skp_en_late();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
